// File: rtl/push_window.sv
// push_window: stretches each delayed push pulse into a write-enable window of
// NWORDS+1 cycles. Pushes arriving during a window are queued and served
// back-to-back; window starts are counted and a dropped push sets a sticky flag.
module push_window #(
  parameter int PEND_W  = 4,
  parameter int EVCNT_W = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PUSH,
  input  logic [4:0]         NWORDS,
  output logic               WE,
  output logic [4:0]         WCNT,
  output logic               FIRST,
  output logic               LAST,
  output logic               BUSY,
  output logic [PEND_W-1:0]  PEND,
  output logic [EVCNT_W-1:0] EVCNT,
  output logic               OVFL
);

  // state | meaning
  // IDLE  | no window active, WE low, queue empty
  // WIN   | window active, WE high, WCNT counts words
  typedef enum logic {S_IDLE, S_WIN} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t               r_state, w_state_nxt;
  logic [4:0]           r_wcnt,  w_wcnt_nxt;
  logic [4:0]           r_len,   w_len_nxt;
  logic                 r_first, w_first_nxt;
  logic                 r_last,  w_last_nxt;
  logic                 r_busy,  w_busy_nxt;
  logic [PEND_W-1:0]    r_pend,  w_pend_nxt;
  logic [EVCNT_W-1:0]   r_evcnt, w_evcnt_nxt;
  logic                 r_ovfl,  w_ovfl_nxt;
  logic                 w_start;

  // A new window may begin when idle or on the last word of the current one.
  assign w_start = ((r_state == S_IDLE) || r_last) && (PUSH || (r_pend != '0));

  // Register all state; reset clears any window in progress and the queue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_len   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_evcnt <= '0;
      r_ovfl  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_len   <= w_len_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_pend  <= w_pend_nxt;
      r_evcnt <= w_evcnt_nxt;
      r_ovfl  <= w_ovfl_nxt;
    end
  end

  // Next-state, window counters and pending-queue bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_len_nxt   = r_len;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    w_pend_nxt  = r_pend;
    w_evcnt_nxt = r_evcnt;
    w_ovfl_nxt  = r_ovfl;

    if (w_start) begin
      // Length is captured here so NWORDS changes mid-window are ignored.
      w_state_nxt = S_WIN;
      w_wcnt_nxt  = '0;
      w_len_nxt   = NWORDS;
      w_first_nxt = 1'b1;
      w_last_nxt  = (NWORDS == 5'd0);
      w_evcnt_nxt = r_evcnt + 1'b1;
    end else if (r_state == S_WIN) begin
      if (r_last) begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end else begin
        w_wcnt_nxt  = r_wcnt + 5'd1;
        w_last_nxt  = ((r_wcnt + 5'd1) == r_len);
      end
    end

    // A push coinciding with a start cancels out; a start alone drains one.
    case ({PUSH, w_start})
      2'b10: begin
        if (r_pend == PEND_MAX) w_ovfl_nxt = 1'b1;
        else                    w_pend_nxt = r_pend + 1'b1;
      end
      2'b01:   w_pend_nxt = r_pend - 1'b1;
      default: w_pend_nxt = r_pend;
    endcase

    w_busy_nxt = (w_state_nxt == S_WIN) || (w_pend_nxt != '0);
  end

  assign WE    = (r_state == S_WIN);
  assign WCNT  = r_wcnt;
  assign FIRST = r_first;
  assign LAST  = r_last;
  assign BUSY  = r_busy;
  assign PEND  = r_pend;
  assign EVCNT = r_evcnt;
  assign OVFL  = r_ovfl;

endmodule

// File: doc/push_window.md
Name: push_window

Overview:
- Sits directly downstream of the programmable push-delay stage.
- Consumes its single-cycle delayed push pulse and expands each pulse into a write-enable window of programmable length for the FIFO write path.
- Pushes that arrive while a window is active are queued and served back-to-back.
- Provides word/event bookkeeping and an overflow flag for the event-builder logic.

Parameters:
- PEND_W, 4, width of the pending-push counter; maximum queued pushes = 2^PEND_W - 1.
- EVCNT_W, 12, width of the window (event) counter; wraps modulo 2^EVCNT_W.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- PUSH  input  1  delayed push pulse from the push-delay stage; sampled every cycle; each high cycle is one request.
- NWORDS  input  5  window length minus one; window = NWORDS+1 cycles (1..32); sampled only at window start.
- WE  output  1  write-enable window.
- WCNT  output  5  word index within the current window, 0..len-1; 0 when WE low.
- FIRST  output  1  high on the first cycle of each window.
- LAST  output  1  high on the final cycle of each window.
- BUSY  output  1  high when WE is high or any push is pending.
- PEND  output  PEND_W  number of queued, not-yet-started pushes.
- EVCNT  output  EVCNT_W  count of windows started.
- OVFL  output  1  sticky: a push was dropped because the queue was full.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched length 0.
- RST has priority over all other activity. A window in progress is terminated: WE drops on the cycle after RST is sampled. The queue is cleared.
- States:
  - IDLE: WE=0.
  - WIN: WE=1.
- start condition = (state==IDLE or LAST) and (PUSH or PEND!=0).
- Start, on the next edge:
  - state=WIN, WCNT=0, FIRST=1.
  - LAST = (NWORDS==0).
  - latched length = NWORDS.
  - EVCNT increments (wraps, no flag).
- Latency: a PUSH sampled in IDLE gives WE high on the next cycle (1 clock).
- In WIN, each edge increments WCNT. FIRST is high only when WCNT==0. LAST is high when WCNT==latched length.
- On the LAST cycle:
  - If the start condition holds, the next window begins with no gap: WE stays high, WCNT returns to 0, FIRST=1.
  - Otherwise the block goes to IDLE and WE=0.
- NWORDS changes mid-window do not affect the current window.
- Pending queue update: PEND_next = PEND + PUSH - start. Case by case:
  - PUSH during WIN but not on LAST: PEND+1.
  - PUSH on LAST while PEND>0: PEND unchanged.
  - PUSH on LAST while PEND==0: PEND stays 0; the new window serves it.
  - No PUSH on LAST while PEND>0: PEND-1.
- Full queue: PUSH with PEND==max and no start in that cycle → push dropped, PEND holds, OVFL set. OVFL clears only on RST.
- In IDLE, PEND is always 0.
- BUSY = WE or (PEND!=0), registered consistently with WE and PEND.
- WCNT never exceeds 31. For a 32-word window, LAST is at WCNT==31.

Test Plan:
- RST, NWORDS=3, single PUSH at cycle 10 → WE high cycles 11-14; WCNT 0,1,2,3; FIRST at 11; LAST at 14; EVCNT=1; BUSY low from 15.
- NWORDS=7; PUSH at cycles 10, 12, 13 → windows at 11-18, 19-26, 27-34 with no gaps; PEND=1 at 13, 2 at 14, 1 from 19, 0 from 27; EVCNT=3.
- NWORDS=3; PUSH at 10 and again on the LAST cycle (14) → second window at 15-18 back-to-back; PEND stays 0 throughout.
- NWORDS=0; PUSH high for 4 consecutive cycles 10-13 → WE high 11-14; FIRST and LAST high every cycle; 4 windows; PEND never exceeds 1.
- NWORDS=31, PEND_W=4; PUSH at 10, then 16 more pushes during the window → PEND saturates at 15; OVFL=1; exactly 16 windows total; OVFL stays 1 until RST.
- Window active with PEND=2; assert RST for 1 cycle → WE, PEND, WCNT, EVCNT, OVFL all 0 the next cycle; a subsequent PUSH starts a fresh window with EVCNT=1.
